// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the multicycle RV32I control FSM
// Purpose: state encoding, ALU opcodes, RV32I opcodes, immediate and mux selects.
// Ports: none (package).
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_EXECU    = 4'd8,
    S_JALRADR  = 4'd9,
    S_JAL      = 4'd10,
    S_BRANCH   = 4'd11,
    S_ALUWB    = 4'd12
  } state_e;

  // Which decode table the ALU decoder applies in the current state.
  typedef enum logic [1:0] {
    OPC_ADD    = 2'd0,
    OPC_RTYPE  = 2'd1,
    OPC_ITYPE  = 2'd2,
    OPC_BRANCH = 2'd3
  } alu_op_class_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_RESULT = 1'b1;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Immediate format is a pure function of the opcode, independent of state.
  function automatic logic [2:0] imm_src_for(input logic [6:0] opcode);
    case (opcode)
      OP_SW:            imm_src_for = IMM_S;
      OP_BRANCH:        imm_src_for = IMM_B;
      OP_JAL:           imm_src_for = IMM_J;
      OP_LUI, OP_AUIPC: imm_src_for = IMM_U;
      default:          imm_src_for = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller-to-datapath bundle for the multicycle core
// Purpose: groups the IR fields, status flags and all control outputs.
// Ports: master = controller (drives enables/selects/alu_ctrl), slave = datapath.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl;
  logic       illegal_op;

  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output pc_write, ir_write, mem_write, reg_write, adr_src,
           alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, illegal_op
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  pc_write, ir_write, mem_write, reg_write, adr_src,
           alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, illegal_op
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// rtl/multicycle_ctrl_alu_decoder.sv - maps op class, funct3, funct7b5 to alu_ctrl
// Purpose: combinational ALU opcode decode.
// Ports: op_class_i, funct3_i, funct7b5_i in; alu_ctrl_o out (4-bit ALU opcode).
module multicycle_ctrl_alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  alu_op_class_e op_class_i,
  input  logic [2:0]    funct3_i,
  input  logic          funct7b5_i,
  output logic [3:0]    alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (op_class_i)
      OPC_BRANCH: begin
        // beq/bne compare by subtraction; signed/unsigned pairs use SLT/SLTU.
        case (funct3_i[2:1])
          2'b10:   alu_ctrl_o = ALU_SLT;
          2'b11:   alu_ctrl_o = ALU_SLTU;
          default: alu_ctrl_o = ALU_SUB;
        endcase
      end
      OPC_RTYPE, OPC_ITYPE: begin
        case (funct3_i)
          // funct7b5 on an I-type add is immediate bits, not a SUB request.
          3'b000:  alu_ctrl_o = (op_class_i == OPC_RTYPE && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b011:  alu_ctrl_o = ALU_SLTU;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - control FSM for the multicycle RV32I datapath
// Purpose: sequences fetch/decode/execute/memory/writeback and drives datapath controls.
// Ports: clk (rising edge), reset (async, active-low), ctrl (multicycle_ctrl_if.master):
//        IR fields, zero and mem_ready in; write enables, mux selects, imm_src,
//        alu_ctrl and illegal_op out.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   ctrl
);

  state_e        state_q;
  state_e        state_d;
  alu_op_class_e op_class_c;

  logic       pc_write_c;
  logic       ir_write_c;
  logic       mem_write_c;
  logic       reg_write_c;
  logic       illegal_c;
  logic       adr_src_c;
  logic [1:0] src_a_c;
  logic [1:0] src_b_c;
  logic [1:0] result_c;
  logic       branch_taken_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // zero reflects the compare op chosen for the branch; SLT/SLTU give 1 when
  // less-than, so zero=0 means "less" and zero=1 means "greater or equal".
  always_comb begin
    branch_taken_c = 1'b0;
    case (ctrl.funct3)
      3'b000:         branch_taken_c = ctrl.zero;
      3'b001:         branch_taken_c = ~ctrl.zero;
      3'b100, 3'b110: branch_taken_c = ~ctrl.zero;
      3'b101, 3'b111: branch_taken_c = ctrl.zero;
      default:        branch_taken_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    adr_src_c   = ADR_PC;
    src_a_c     = SRCA_PC;
    src_b_c     = SRCB_RS2;
    result_c    = RES_ALUOUT;
    op_class_c  = OPC_ADD;

    case (state_q)
      S_FETCH: begin
        src_b_c  = SRCB_FOUR;
        result_c = RES_ALU;
        if (ctrl.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Old PC + imm lands in ALU-out for a later branch/jal target.
        src_a_c = SRCA_OLDPC;
        src_b_c = SRCB_IMM;
        case (ctrl.opcode)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_R:             state_d = S_EXECR;
          OP_I:             state_d = S_EXECI;
          OP_LUI, OP_AUIPC: state_d = S_EXECU;
          OP_JAL:           state_d = S_JAL;
          OP_JALR:          state_d = S_JALRADR;
          OP_BRANCH:        state_d = S_BRANCH;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        src_a_c = SRCA_RS1;
        src_b_c = SRCB_IMM;
        state_d = (ctrl.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src_c = ADR_RESULT;
        if (ctrl.mem_ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        result_c    = RES_DATA;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_c   = ADR_RESULT;
        mem_write_c = 1'b1;
        if (ctrl.mem_ready) begin
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        src_a_c    = SRCA_RS1;
        src_b_c    = SRCB_RS2;
        op_class_c = OPC_RTYPE;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        src_a_c    = SRCA_RS1;
        src_b_c    = SRCB_IMM;
        op_class_c = OPC_ITYPE;
        state_d    = S_ALUWB;
      end
      S_EXECU: begin
        src_a_c = (ctrl.opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        src_b_c = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_JALRADR: begin
        // rs1 + imm replaces the DECODE-time target in ALU-out.
        src_a_c = SRCA_RS1;
        src_b_c = SRCB_IMM;
        state_d = S_JAL;
      end
      S_JAL: begin
        // PC <- target from ALU-out while the ALU forms the link value old PC + 4.
        src_a_c    = SRCA_OLDPC;
        src_b_c    = SRCB_FOUR;
        result_c   = RES_ALUOUT;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        result_c    = RES_ALUOUT;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        src_a_c    = SRCA_RS1;
        src_b_c    = SRCB_RS2;
        result_c   = RES_ALUOUT;
        op_class_c = OPC_BRANCH;
        pc_write_c = branch_taken_c;
        state_d    = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  multicycle_ctrl_alu_decoder u_alu_decoder (
    .op_class_i (op_class_c),
    .funct3_i   (ctrl.funct3),
    .funct7b5_i (ctrl.funct7b5),
    .alu_ctrl_o (ctrl.alu_ctrl)
  );

  // Any write during reset would corrupt architectural state, so gate them here.
  assign ctrl.pc_write   = pc_write_c & reset;
  assign ctrl.ir_write   = ir_write_c & reset;
  assign ctrl.mem_write  = mem_write_c & reset;
  assign ctrl.reg_write  = reg_write_c & reset;
  assign ctrl.illegal_op = illegal_c & reset;
  assign ctrl.adr_src    = adr_src_c;
  assign ctrl.alu_src_a  = src_a_c;
  assign ctrl.alu_src_b  = src_b_c;
  assign ctrl.result_src = result_c;
  assign ctrl.imm_src    = imm_src_for(ctrl.opcode);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset;

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BR = 7'b1100011, LUI = 7'b0110111, AUIPC = 7'b0010111;

  typedef struct {
    int         cycles;
    int         n_pc;
    int         n_ir;
    int         n_reg;
    int         n_mem;
    int         n_ill;
    int         pc_idx;
    int         reg_idx;
    logic [3:0] alu2;
    logic [1:0] a2;
    logic [1:0] b2;
    bit         alu_chk;
    bit         ab_chk;
  } res_t;

  // Runs one instruction starting in FETCH, just after a rising edge. Fetch is
  // stalled fs cycles, the memory access ms cycles; mem_ready is random elsewhere.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input int fs, input int ms, output res_t r);
    bit done = 0;
    bit memop = (op == LW) || (op == SW);
    r = '{default: 0};
    r.pc_idx = -1;
    r.reg_idx = -1;
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7b5 = f7;
    bus.zero = z;
    for (int c = 0; c < 40 && !done; c++) begin
      int p = c - fs;
      if (c < fs) bus.mem_ready = 1'b0;
      else if (c == fs) bus.mem_ready = 1'b1;
      else if (memop && p >= 3 && p < 3 + ms) bus.mem_ready = 1'b0;
      else if (memop && p == 3 + ms) bus.mem_ready = 1'b1;
      else bus.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      r.cycles++;
      if (bus.pc_write) begin r.n_pc++; r.pc_idx = c; end
      if (bus.reg_write) begin r.n_reg++; r.reg_idx = c; end
      if (bus.ir_write) r.n_ir++;
      if (bus.mem_write) r.n_mem++;
      if (bus.illegal_op) r.n_ill++;
      if (p == 2) begin
        r.alu2 = bus.alu_ctrl;
        r.a2 = bus.alu_src_a;
        r.b2 = bus.alu_src_b;
      end
      @(posedge clk);
      #1;
      if (c >= fs && bus.alu_src_a == 2'b00 && bus.alu_src_b == 2'b10) done = 1;
    end
    if (!done) r.cycles = -1;
  endtask

  // Instruction-level expectations: cycle budget, write pulses and execute-step controls.
  function automatic res_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic z, input int fs, input int ms);
    res_t e;
    int base = 0;
    bit reg_wr = 0;
    bit mem_cls = 0;
    int extra_pc = -1;
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd3, 4'd2};
    e = '{default: 0};
    e.ab_chk = 1;
    e.alu_chk = 1;
    e.n_ir = 1;
    case (op)
      LW:    begin base = 5; reg_wr = 1; mem_cls = 1; e.a2 = 2; e.b2 = 1; e.alu2 = 0; end
      SW:    begin base = 4; mem_cls = 1; e.n_mem = 1 + ms; e.a2 = 2; e.b2 = 1; e.alu2 = 0; end
      RT: begin
        base = 4; reg_wr = 1; e.a2 = 2; e.b2 = 0; e.alu2 = tbl[f3];
        if (f7 && f3 == 3'd0) e.alu2 = 4'd1;
        if (f7 && f3 == 3'd5) e.alu2 = 4'd9;
      end
      IT: begin
        base = 4; reg_wr = 1; e.a2 = 2; e.b2 = 1; e.alu2 = tbl[f3];
        if (f7 && f3 == 3'd5) e.alu2 = 4'd9;
      end
      LUI:   begin base = 4; reg_wr = 1; e.a2 = 3; e.b2 = 1; e.alu2 = 0; end
      AUIPC: begin base = 4; reg_wr = 1; e.a2 = 1; e.b2 = 1; e.alu2 = 0; end
      JAL:   begin base = 4; reg_wr = 1; e.a2 = 1; e.b2 = 2; e.alu2 = 0; end
      JALR:  begin base = 5; reg_wr = 1; e.a2 = 2; e.b2 = 1; e.alu2 = 0; end
      BR: begin
        base = 3; e.a2 = 2; e.b2 = 0;
        case (f3)
          3'd0, 3'd1: e.alu2 = 4'd1;
          3'd4, 3'd5: e.alu2 = 4'd5;
          3'd6, 3'd7: e.alu2 = 4'd6;
          default:    e.alu_chk = 0;
        endcase
      end
      default: begin base = 2; e.n_ill = 1; e.ab_chk = 0; e.alu_chk = 0; end
    endcase
    e.cycles = base + fs + (mem_cls ? ms : 0);
    e.n_reg = reg_wr ? 1 : 0;
    e.reg_idx = reg_wr ? e.cycles - 1 : -1;
    if (op == JAL || op == JALR) extra_pc = e.cycles - 2;
    if (op == BR) begin
      bit taken;
      case (f3)
        3'd0, 3'd5, 3'd7: taken = z;
        3'd1, 3'd4, 3'd6: taken = ~z;
        default:          taken = 0;
      endcase
      if (taken) extra_pc = e.cycles - 1;
    end
    e.n_pc = (extra_pc >= 0) ? 2 : 1;
    e.pc_idx = (extra_pc >= 0) ? extra_pc : fs;
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = 7'b1111111;
    bus.funct3 = 3'd0;
    bus.funct7b5 = 1'b0;
    bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write, bus.illegal_op} !== 5'b0) begin
      fails++;
      $display("FAIL reset_enables: got %b want 00000",
               {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write, bus.illegal_op});
    end
    tests++;
    if ({bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_ctrl} !== 10'b00_10_10_0000) begin
      fails++;
      $display("FAIL reset_fetch_selects: got %b want 0010100000",
               {bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_ctrl});
    end
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rtype_sub();
    res_t o;
    run_instr(RT, 3'd0, 1'b1, 1'b0, 0, 0, o);
    tests++;
    if (o.cycles != 4) begin fails++; $display("FAIL sub_cycles: got %0d want 4", o.cycles); end
    tests++;
    if (o.alu2 !== 4'b0001) begin fails++; $display("FAIL sub_alu: got %b want 0001", o.alu2); end
    tests++;
    if (o.n_reg != 1 || o.reg_idx != 3) begin
      fails++; $display("FAIL sub_regwrite: got n=%0d idx=%0d want n=1 idx=3", o.n_reg, o.reg_idx);
    end
  endtask

  task automatic test_imm_shift();
    res_t o;
    run_instr(IT, 3'd5, 1'b1, 1'b0, 0, 0, o);
    tests++;
    if (o.alu2 !== 4'b1001) begin fails++; $display("FAIL srai_alu: got %b want 1001", o.alu2); end
    run_instr(IT, 3'd0, 1'b1, 1'b0, 0, 0, o);
    tests++;
    if (o.alu2 !== 4'b0000) begin fails++; $display("FAIL addi_f7_alu: got %b want 0000", o.alu2); end
    tests++;
    if (o.cycles != 4) begin fails++; $display("FAIL addi_cycles: got %0d want 4", o.cycles); end
  endtask

  task automatic test_lw_stall();
    res_t o;
    run_instr(LW, 3'd2, 1'b0, 1'b0, 0, 2, o);
    tests++;
    if (o.cycles != 7) begin fails++; $display("FAIL lw_stall_cycles: got %0d want 7", o.cycles); end
    tests++;
    if (o.n_reg != 1 || o.reg_idx != 6) begin
      fails++; $display("FAIL lw_regwrite: got n=%0d idx=%0d want n=1 idx=6", o.n_reg, o.reg_idx);
    end
  endtask

  task automatic test_branch();
    res_t o;
    run_instr(BR, 3'd5, 1'b0, 1'b1, 0, 0, o);
    tests++;
    if (o.n_pc != 2 || o.pc_idx != 2 || o.cycles != 3) begin
      fails++; $display("FAIL bge_taken: got pc=%0d idx=%0d cyc=%0d want 2 2 3", o.n_pc, o.pc_idx, o.cycles);
    end
    run_instr(BR, 3'd1, 1'b0, 1'b1, 0, 0, o);
    tests++;
    if (o.n_pc != 1 || o.cycles != 3) begin
      fails++; $display("FAIL bne_not_taken: got pc=%0d cyc=%0d want 1 3", o.n_pc, o.cycles);
    end
  endtask

  task automatic test_jalr();
    res_t o;
    run_instr(JALR, 3'd0, 1'b0, 1'b0, 0, 0, o);
    tests++;
    if (o.cycles != 5 || o.pc_idx != 3 || o.reg_idx != 4) begin
      fails++; $display("FAIL jalr_seq: got cyc=%0d pc_idx=%0d reg_idx=%0d want 5 3 4",
                        o.cycles, o.pc_idx, o.reg_idx);
    end
    tests++;
    if (o.a2 !== 2'b10) begin fails++; $display("FAIL jalradr_srca: got %b want 10", o.a2); end
  endtask

  task automatic test_illegal();
    res_t o;
    run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0, o);
    tests++;
    if (o.n_ill != 1 || o.cycles != 2 || o.n_reg != 0 || o.n_pc != 1) begin
      fails++; $display("FAIL illegal: got ill=%0d cyc=%0d reg=%0d pc=%0d want 1 2 0 1",
                        o.n_ill, o.cycles, o.n_reg, o.n_pc);
    end
  endtask

  task automatic test_reset_midway();
    bus.opcode = SW;
    bus.funct3 = 3'd2;
    bus.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
    #1;
    tests++;
    if (bus.mem_write !== 1'b1) begin fails++; $display("FAIL memwrite_before_reset: got %b want 1", bus.mem_write); end
    reset = 1'b0;
    #1;
    tests++;
    if (bus.mem_write !== 1'b0 || bus.alu_src_b !== 2'b10) begin
      fails++; $display("FAIL reset_abort: got mw=%b b=%b want 0 10", bus.mem_write, bus.alu_src_b);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.alu_src_a !== 2'b00 || bus.alu_src_b !== 2'b10 || bus.mem_write !== 1'b0) begin
      fails++; $display("FAIL after_release: got a=%b b=%b mw=%b want 00 10 0",
                        bus.alu_src_a, bus.alu_src_b, bus.mem_write);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    logic [6:0] bad [4];
    ops = '{LW, SW, RT, IT, LUI, AUIPC, JAL, JALR, BR, 7'b0};
    bad = '{7'b0000000, 7'b1111111, 7'b0001111, 7'b1110011};
    for (int i = 0; i < 60; i++) begin
      res_t o;
      res_t e;
      int k = $urandom_range(0, 9);
      logic [6:0] op = (k == 9) ? bad[$urandom_range(0, 3)] : ops[k];
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      logic f7 = 1'($urandom_range(0, 1));
      logic z = 1'($urandom_range(0, 1));
      int fs = $urandom_range(0, 2);
      int ms = $urandom_range(0, 3);
      run_instr(op, f3, f7, z, fs, ms, o);
      e = model(op, f3, f7, z, fs, ms);
      tests++;
      if (o.cycles != e.cycles) begin fails++; $display("FAIL rand%0d_cycles op=%b: got %0d want %0d", i, op, o.cycles, e.cycles); end
      tests++;
      if (o.n_pc != e.n_pc || o.pc_idx != e.pc_idx) begin
        fails++; $display("FAIL rand%0d_pcwrite op=%b f3=%0d: got %0d@%0d want %0d@%0d", i, op, f3, o.n_pc, o.pc_idx, e.n_pc, e.pc_idx);
      end
      tests++;
      if (o.n_reg != e.n_reg || o.reg_idx != e.reg_idx) begin
        fails++; $display("FAIL rand%0d_regwrite op=%b: got %0d@%0d want %0d@%0d", i, op, o.n_reg, o.reg_idx, e.n_reg, e.reg_idx);
      end
      tests++;
      if (o.n_ir != e.n_ir || o.n_mem != e.n_mem || o.n_ill != e.n_ill) begin
        fails++; $display("FAIL rand%0d_pulses op=%b: got ir=%0d mw=%0d ill=%0d want %0d %0d %0d",
                          i, op, o.n_ir, o.n_mem, o.n_ill, e.n_ir, e.n_mem, e.n_ill);
      end
      if (e.alu_chk) begin
        tests++;
        if (o.alu2 !== e.alu2) begin fails++; $display("FAIL rand%0d_alu op=%b f3=%0d f7=%b: got %b want %b", i, op, f3, f7, o.alu2, e.alu2); end
      end
      if (e.ab_chk) begin
        tests++;
        if (o.a2 !== e.a2 || o.b2 !== e.b2) begin
          fails++; $display("FAIL rand%0d_srcs op=%b: got %b/%b want %b/%b", i, op, o.a2, o.b2, e.a2, e.b2);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rtype_sub();
    test_imm_shift();
    test_lw_stall();
    test_branch();
    test_jalr();
    test_illegal();
    test_reset_midway();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the multicycle RV32I datapath. It is the initiator side of the ALU interface. Each cycle it sequences fetch, decode, execute, memory and writeback, and drives the datapath mux selects, the write enables and the 4-bit ALU opcode that the ALU consumes. It sits between the instruction register/memory port and the shared datapath (PC, IR, old-PC, data, ALU-out registers and the register file).

## Interface
- No parameters. Encodings are fixed in the shared package.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low.
- `opcode` in 7: instr[6:0] from the IR.
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write`, `ir_write`, `mem_write`, `reg_write` out 1: write enables.
- `adr_src` out 1: memory address select. 0 = PC, 1 = Result.
- `alu_src_a` out 2: 00 PC, 01 old PC, 10 rs1, 11 constant 0.
- `alu_src_b` out 2: 00 rs2, 01 imm, 10 constant 4.
- `result_src` out 2: 00 ALU-out register, 01 data register, 10 ALU result.
- `imm_src` out 3: 000 I, 001 S, 010 B, 011 J, 100 U. Combinational from `opcode` in every state.
- `alu_ctrl` out 4: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLL, 0101 SLT, 0110 SLTU, 0111 XOR, 1000 SRL, 1001 SRA.
- `illegal_op` out 1: one-cycle pulse on an unrecognised opcode.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, EXECU, JALRADR, JAL, BRANCH, ALUWB.
- Opcodes handled: lw 0000011, sw 0100011, R 0110011, I 0010011, jal 1101111, jalr 1100111, branch 1100011, lui 0110111, auipc 0010111.
- FETCH
  - Drives adr_src=0, a=00, b=10, ADD, result_src=10.
  - `ir_write` and `pc_write` assert only in the cycle where `mem_ready`=1; the FSM holds in FETCH otherwise.
  - Transitions to DECODE.
- DECODE: a=01, b=01, ADD, which precomputes the branch/jal target into ALU-out. Dispatches on opcode:
  - lw/sw → MEMADR
  - R → EXECR
  - I → EXECI
  - lui/auipc → EXECU
  - jal → JAL
  - jalr → JALRADR
  - branch → BRANCH
  - any other opcode → FETCH, with `illegal_op`=1 for one cycle.
- MEMADR: a=10, b=01, ADD. lw → MEMREAD; sw → MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Holds until `mem_ready`, then → MEMWB.
- MEMWB: result_src=01, reg_write=1, then → FETCH.
- MEMWRITE: adr_src=1, result_src=00. `mem_write` is asserted for every cycle in the state. Exits to FETCH on `mem_ready`.
- EXECR and EXECI: a=10. b=00 in EXECR, b=01 in EXECI. Then → ALUWB.
- `alu_ctrl` decode by funct3:
  - 000: ADD. SUB only in EXECR with funct7b5=1.
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRA when funct7b5=1, else SRL. Applies in both EXECR and EXECI.
  - 110: OR
  - 111: AND
- EXECU: a=11 for lui, 01 for auipc; b=01; ADD; then → ALUWB.
- JALRADR: a=10, b=01, ADD, then → JAL.
- JAL: a=01, b=10, ADD, result_src=00, pc_write=1, then → ALUWB.
- ALUWB: result_src=00, reg_write=1, then → FETCH.
- BRANCH: a=10, b=00, result_src=00, then → FETCH.
  - `alu_ctrl` is SUB for beq/bne, SLT for blt/bge, SLTU for bltu/bgeu.
  - `pc_write` is taken as follows: beq = zero, bne = ~zero, blt/bltu = ~zero, bge/bgeu = zero. funct3 010/011 is never taken.
- Control outputs not listed for a state are 0.
- `alu_ctrl` defaults to ADD outside the execute states.

## Timing
- State register updates on posedge `clk`. All outputs are combinational from state plus the IR fields, `zero` and `mem_ready`.
- Cycle counts with `mem_ready` tied high:
  - lw 5
  - sw, R, I, lui, auipc, jal 4
  - jalr 5
  - branch 3
- Each `mem_ready`-low cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset asserted: state goes to FETCH immediately. While `reset`=0, all write enables are forced to 0 and `illegal_op`=0.
- Reset mid-instruction aborts the instruction with no further writes.
- On release, the first FETCH begins at the next edge.

## Structure
- Shared package/include `ctrl_defs` holds:
  - state encoding (4-bit)
  - ALU opcode constants
  - RV32I opcode constants
  - imm_src and mux-select constants
- Sub-module `alu_decoder` (combinational): maps op-class, funct3 and funct7b5 to `alu_ctrl`. The FSM instantiates it once.

## Test plan
- R-type sub (opcode 0110011, funct3 000, funct7b5 1), `mem_ready`=1 → states FETCH→DECODE→EXECR→ALUWB; alu_ctrl=0001 in EXECR; reg_write=1 only in cycle 4.
- srai (0010011, funct3 101, funct7b5 1) → alu_ctrl=1001; addi with funct7b5=1 → alu_ctrl=0000.
- lw with `mem_ready` low for 2 cycles in MEMREAD → 7 cycles total; reg_write pulses once, in MEMWB.
- bge with zero=1 → pc_write=1 in BRANCH; bne with zero=1 → pc_write=0; both are 3 cycles.
- jalr → FETCH, DECODE, JALRADR, JAL, ALUWB; pc_write in JAL; reg_write in ALUWB.
- opcode 1111111 → illegal_op pulses in DECODE, then FETCH. `reset` dropped during MEMWRITE → mem_write=0 at once; state FETCH after release.
